// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares one single-port data RAM between the processor data port (port 0,
// priority) and the debug/DMA loader (port 1). One access is granted per
// cycle. The granted port's address, write data and write enable are muxed
// onto the RAM. The 1-cycle read-data valid is routed back to the port that
// issued the read. Port 1 is force-granted after MAX_WAIT cycles of waiting,
// and it may hold the grant for up to BURST_MAX cycles with p1_lock_i.
//
// Optional build macro: DMEM_ARB_RR_EN. When it is defined, round-robin
// replaces fixed port-0 priority for contention that is not decided by the
// lock or starvation rules.
//
// Ports:
//   clk_i, rst_i                      clock (rising), async active-high reset
//   p0_req_i/we_i/addr_i/wdata_i      port 0 request bundle
//   p0_gnt_o (comb), p0_rvalid_o, p0_rdata_o
//   p1_req_i/we_i/lock_i/addr_i/wdata_i  port 1 request bundle
//   p1_gnt_o (comb), p1_rvalid_o, p1_rdata_o
//   mem_addr_o, mem_wdata_o, mem_wr_o, mem_rdata_i  RAM side
module dmem_port_arbiter #(
    parameter int unsigned AW        = 16,
    parameter int unsigned DW        = 16,
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned BURST_MAX = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          p0_req_i,
    input  logic          p0_we_i,
    input  logic [AW-1:0] p0_addr_i,
    input  logic [DW-1:0] p0_wdata_i,
    output logic          p0_gnt_o,
    output logic          p0_rvalid_o,
    output logic [DW-1:0] p0_rdata_o,
    input  logic          p1_req_i,
    input  logic          p1_we_i,
    input  logic          p1_lock_i,
    input  logic [AW-1:0] p1_addr_i,
    input  logic [DW-1:0] p1_wdata_i,
    output logic          p1_gnt_o,
    output logic          p1_rvalid_o,
    output logic [DW-1:0] p1_rdata_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_wr_o,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int unsigned BURST_W = $clog2(BURST_MAX + 1);

    logic               lock_q, lock_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               rv0_q, rv0_d;
    logic               rv1_q, rv1_d;
`ifdef DMEM_ARB_RR_EN
    logic               last_gnt_q, last_gnt_d;
`endif

    logic gnt0_c, gnt1_c;
    logic lock_hold_c, starve_c;

    // Grant decision: lock hold, then starvation, then p0/p1 arbitration.
    always_comb begin
        gnt0_c      = 1'b0;
        gnt1_c      = 1'b0;
        lock_hold_c = lock_q & p1_req_i & (burst_cnt_q < BURST_W'(BURST_MAX));
        starve_c    = p1_req_i & (wait_cnt_q == WAIT_W'(MAX_WAIT));
        if (rst_i) begin
            gnt0_c = 1'b0;
            gnt1_c = 1'b0;
        end else if (lock_hold_c || starve_c) begin
            gnt1_c = 1'b1;
`ifdef DMEM_ARB_RR_EN
        end else if (p0_req_i && p1_req_i) begin
            // The port that was not granted last wins the contention.
            gnt0_c = last_gnt_q;
            gnt1_c = ~last_gnt_q;
`endif
        end else if (p0_req_i) begin
            gnt0_c = 1'b1;
        end else if (p1_req_i) begin
            gnt1_c = 1'b1;
        end
    end

    // Next-state for the wait/lock/burst counters and read-valid pipeline.
    always_comb begin
        wait_cnt_d  = '0;
        lock_d      = 1'b0;
        burst_cnt_d = '0;
        rv0_d       = gnt0_c & ~p0_we_i;
        rv1_d       = gnt1_c & ~p1_we_i;
        if (p1_req_i && !gnt1_c) begin
            wait_cnt_d = (wait_cnt_q == WAIT_W'(MAX_WAIT)) ? wait_cnt_q
                                                            : wait_cnt_q + WAIT_W'(1);
        end
        // Any cycle without a locked p1 grant ends the lock.
        if (gnt1_c && p1_lock_i) begin
            lock_d      = 1'b1;
            burst_cnt_d = (burst_cnt_q == BURST_W'(BURST_MAX)) ? burst_cnt_q
                                                                : burst_cnt_q + BURST_W'(1);
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Remember the last granted port for round-robin.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt0_c) begin
            last_gnt_d = 1'b0;
        end else if (gnt1_c) begin
            last_gnt_d = 1'b1;
        end
    end
`endif

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q      <= 1'b0;
            burst_cnt_q <= '0;
            wait_cnt_q  <= '0;
            rv0_q       <= 1'b0;
            rv1_q       <= 1'b0;
        end else begin
            lock_q      <= lock_d;
            burst_cnt_q <= burst_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            rv0_q       <= rv0_d;
            rv1_q       <= rv1_d;
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Reset to port 1 so that port 0 wins the first contention.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    // RAM-side mux; the bus is driven to zero when no port is granted.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wr_o    = 1'b0;
        if (gnt0_c) begin
            mem_addr_o  = p0_addr_i;
            mem_wdata_o = p0_wdata_i;
            mem_wr_o    = p0_we_i;
        end else if (gnt1_c) begin
            mem_addr_o  = p1_addr_i;
            mem_wdata_o = p1_wdata_i;
            mem_wr_o    = p1_we_i;
        end
    end

    assign p0_gnt_o    = gnt0_c;
    assign p1_gnt_o    = gnt1_c;
    assign p0_rvalid_o = rv0_q;
    assign p1_rvalid_o = rv1_q;
    assign p0_rdata_o  = mem_rdata_i;
    assign p1_rdata_o  = mem_rdata_i;

endmodule
